// File: rtl/sdram_init_seq_if.sv
// sdram_init_seq_if: SDRAM command bus plus init status/request between the sequencer and its user.
interface sdram_init_seq_if;
  logic reinit, cke, cs, ras, cas, we, init_done;
  logic [1:0] ba;
  logic [11:0] addr;
  logic [2:0] init_state;
  modport master(input reinit, output cke, cs, ras, cas, we, ba, addr, init_done, init_state);
  modport slave(output reinit, input cke, cs, ras, cas, we, ba, addr, init_done, init_state);
endinterface

// File: rtl/sdram_init_seq.sv
// sdram_init_seq: power-up sequencer (wait, precharge all, two auto refreshes, load mode register).
module sdram_init_seq #(
  parameter int INIT_WAIT_CYCLES = 5000,
  parameter int TRP = 2,
  parameter int TRFC = 7,
  parameter int TMRD = 2,
  parameter logic [11:0] MODE_REG = 12'h033
) (
  input logic sys_clk,
  input logic reset,
  sdram_init_seq_if.master bus
);
  typedef enum logic [2:0] {RST, WAIT, PRE, REF1, REF2, LMR, GAP, DONE} state_t;
  localparam logic [3:0] INH = 4'b1111, NOP = 4'b0111, PRECH = 4'b0010, AREF = 4'b0001, LMRC = 4'b0000;
  state_t state, tgt;
  logic [15:0] cnt;
  assign bus.init_state = state;
  // Outputs are registered alongside the state they belong to, so each command lines up with its state.
  always_ff @(posedge sys_clk or posedge reset)
    if (reset) begin
      state <= RST;
      tgt <= REF1;
      cnt <= 16'(INIT_WAIT_CYCLES);
      bus.cke <= 1'b0;
      {bus.cs, bus.ras, bus.cas, bus.we} <= INH;
      bus.ba <= 2'b00;
      bus.addr <= 12'h000;
      bus.init_done <= 1'b0;
    end else begin
      bus.cke <= 1'b1;
      {bus.cs, bus.ras, bus.cas, bus.we} <= NOP;
      bus.ba <= 2'b00;
      bus.addr <= 12'h000;
      bus.init_done <= 1'b0;
      case (state)
        RST: begin
          state <= WAIT;
          cnt <= 16'(INIT_WAIT_CYCLES);
        end
        WAIT: begin
          cnt <= cnt - 16'd1;
          if (cnt == 16'd1) begin
            state <= PRE;
            {bus.cs, bus.ras, bus.cas, bus.we} <= PRECH;
            bus.addr <= 12'h400;
          end
        end
        PRE: begin
          state <= GAP;
          cnt <= 16'(TRP);
          tgt <= REF1;
        end
        REF1: begin
          state <= GAP;
          cnt <= 16'(TRFC);
          tgt <= REF2;
        end
        REF2: begin
          state <= GAP;
          cnt <= 16'(TRFC);
          tgt <= LMR;
        end
        LMR: begin
          state <= GAP;
          cnt <= 16'(TMRD);
          tgt <= DONE;
        end
        GAP: begin
          cnt <= cnt - 16'd1;
          if (cnt == 16'd1) begin
            state <= tgt;
            {bus.cs, bus.ras, bus.cas, bus.we} <= (tgt == LMR) ? LMRC : (tgt == DONE) ? NOP : AREF;
            bus.addr <= (tgt == LMR) ? MODE_REG : 12'h000;
            bus.init_done <= tgt == DONE;
          end
        end
        DONE:
          if (bus.reinit) begin
            state <= WAIT;
            cnt <= 16'(INIT_WAIT_CYCLES);
          end else bus.init_done <= 1'b1;
      endcase
    end
endmodule

// File: doc/sdram_init_seq.md
SDRAM_INIT_SEQ -- requirements
Module: sdram_init_seq

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- INIT_WAIT_CYCLES, 5000: NOP cycles before PRECHARGE (100 us at a 20 ns clock); legal range 1..65535.
- TRP, 2: NOP cycles after PRECHARGE; legal range 1..15.
- TRFC, 7: NOP cycles after each AUTO REFRESH; legal range 1..15.
- TMRD, 2: NOP cycles after LOAD MODE REGISTER; legal range 1..15.
- MODE_REG, 12'h033: value driven on addr during LOAD MODE REGISTER (burst length 8, CAS latency 3).

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- sys_clk, in, 1: single clock; all logic on its rising edge.
- reset, in, 1: asynchronous, active-high reset.
- reinit, in, 1: one-cycle synchronous request to rerun the sequence.
- cke, out, 1: SDRAM clock enable.
- cs, out, 1: chip select, active low.
- ras, out, 1: row strobe, active low.
- cas, out, 1: column strobe, active low.
- we, out, 1: write enable, active low.
- ba, out, 2: bank address.
- addr, out, 12: SDRAM address.
- init_done, out, 1: high once the sequence has completed.
- init_state, out, 3: current FSM state encoding, for debug.

Function
REQ-003 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-004 The block SHALL drive the following command encodings on {cs,ras,cas,we}:
- INHIBIT = 1xxx, driven as 1111.
- NOP = 0111.
- PRECHARGE = 0010.
- AUTO REFRESH = 0001.
- LOAD MODE REGISTER = 0000.
REQ-005 The FSM SHALL have the states RST(0), WAIT(1), PRE(2), REF1(3), REF2(4), LMR(5), GAP(6) and DONE(7); init_state SHALL equal the current state.
REQ-006 A 16-bit down-counter SHALL time WAIT and GAP; the gap return target (REF1, REF2, LMR or DONE) SHALL be held in a register.
REQ-007 In RST the block SHALL drive INHIBIT with cke=0, and on the first edge after reset release it SHALL set cke=1 and enter WAIT.
REQ-008 WAIT SHALL drive NOP for exactly INIT_WAIT_CYCLES cycles, then enter PRE.
REQ-009 PRE SHALL drive PRECHARGE for one cycle with addr[10]=1 (all banks), the other addr bits 0 and ba=0, then enter GAP for TRP cycles with target REF1.
REQ-010 REF1 SHALL drive AUTO REFRESH for one cycle, then enter GAP for TRFC cycles with target REF2.
REQ-011 REF2 SHALL drive AUTO REFRESH for one cycle, then enter GAP for TRFC cycles with target LMR.
REQ-012 LMR SHALL drive LOAD MODE REGISTER for one cycle with addr=MODE_REG and ba=0, then enter GAP for TMRD cycles with target DONE.
REQ-013 GAP SHALL drive NOP, addr=0 and ba=0.
REQ-014 In DONE the block SHALL set init_done=1 and drive NOP indefinitely with cke=1.
REQ-015 Command cycles SHALL be numbered from edge 1, the first edge after reset release. With the defaults:
- Edges 1..5000: NOP.
- Edge 5001: PRECHARGE.
- Edge 5004: REF1.
- Edge 5012: REF2.
- Edge 5020: LMR.
- Edge 5023: init_done rises.
REQ-016 Every command SHALL be asserted for exactly one cycle, and every cycle of the sequence SHALL be either NOP or one of the four listed commands.
REQ-017 The block SHALL react to reinit only in DONE: on the next edge it SHALL clear init_done, reload the counter with INIT_WAIT_CYCLES and enter WAIT, keeping cke=1; the cycle timing from REQ-008 onward SHALL then repeat.
REQ-018 In any state other than DONE, the block SHALL ignore reinit, including when reinit coincides with the last GAP cycle.
REQ-019 When a counter reaches 0 the block SHALL advance state on that same edge; the counter SHALL never wrap below 0.
REQ-020 A reset asserted at any point SHALL immediately abort the sequence with the behaviour in REQ-021, and after release the sequence SHALL restart from RST in full.

Reset
REQ-021 While reset is high, the block SHALL asynchronously force:
- state=RST, cke=0, cs=ras=cas=we=1.
- ba=0, addr=0.
- init_done=0.
- counter=INIT_WAIT_CYCLES, gap target=REF1.
REQ-022 The block SHALL hold no state that survives reset.

Verification
REQ-023 The bench SHALL cover the following scenarios:
- Default parameters, reset high 5 cycles then released: exactly 5000 NOP cycles (cs=0); PRECHARGE at edge 5001 with addr=12'h400; REF at 5004 and 5012; LMR with addr=12'h033 at 5020; init_done=1 at 5023.
- INIT_WAIT_CYCLES=1, TRP=TRFC=TMRD=1: PRE at edge 2, REF1 at 4, REF2 at 6, LMR at 8, init_done at 10.
- Reset asserted mid-GAP after REF1, asynchronously (between edges): outputs return to 1111 with cke=0 before the next edge; after release the full sequence replays from edge 1.
- reinit pulsed in DONE: init_done=0 on the next edge, then 5000 NOPs and the sequence repeats; cke stays 1 throughout.
- reinit pulsed during WAIT and during the final TMRD cycle: no effect; edge timing identical to scenario 1.
- Throughout every run: one-hot single-cycle commands, no X on cs/ras/cas/we once reset is released, and the gap counter never underflows.
